// File: rtl/fetch_queue_pkg.sv
// Shared defines for the fetch/decode front end: default widths, queue depth and the NOP encoding.
package fetch_queue_pkg;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned DEF_ILEN = 32;
  localparam int unsigned FQ_DEPTH = 4;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between IFU and decode: circular FIFO of {pc, instr} pairs, head exposed to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned ILEN  = DEF_ILEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifu_valid,
  input  logic [XLEN-1:0]            ifu_pc,
  input  logic [ILEN-1:0]            ifu_instr,
  output logic                       fq_full,
  input  logic                       stall_fetch,
  input  logic                       flush_decode,
  output logic                       dec_valid,
  output logic [XLEN-1:0]            dec_pc,
  output logic [ILEN-1:0]            dec_instr,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = XLEN + ILEN;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (count == '0);

  // Full-and-pop still rejects the push so stall_fetch never reaches the IFU combinationally.
  assign push = ifu_valid && (count < CW'(DEPTH)) && !flush_decode;
  assign pop  = !empty && !stall_fetch && !flush_decode;

  // Queue state: flush and reset both return pointers and count to zero; mem is left stale.
  always_ff @(posedge clk) begin
    if (rst || flush_decode) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {ifu_pc, ifu_instr};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign dec_valid = !empty;
  assign dec_pc    = empty ? '0 : head[EW-1:ILEN];
  assign dec_instr = empty ? ILEN'(NOP_INSTR) : head[ILEN-1:0];
  assign fq_full   = (count == CW'(DEPTH));
  assign fq_count  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_instr;
  logic        fq_full;
  logic        stall_fetch;
  logic        flush_decode;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [2:0]  fq_count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_valid    (ifu_valid),
    .ifu_pc       (ifu_pc),
    .ifu_instr    (ifu_instr),
    .fq_full      (fq_full),
    .stall_fetch  (stall_fetch),
    .flush_decode (flush_decode),
    .dec_valid    (dec_valid),
    .dec_pc       (dec_pc),
    .dec_instr    (dec_instr),
    .fq_count     (fq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} updated on every rising edge.
  logic [63:0] mq[$];
  bit          model_ok = 0;

  always @(posedge clk) begin
    int  sz;
    bit  do_push;
    bit  do_pop;
    sz = mq.size();
    if (rst || flush_decode) begin
      mq.delete();
    end else begin
      do_pop  = (sz > 0) && !stall_fetch;
      do_push = ifu_valid && (sz < int'(DEPTH));
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({ifu_pc, ifu_instr});
    end
    if (rst) model_ok = 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_count", 64'(fq_count), 64'(mq.size()));
      chk("m_full", 64'(fq_full), 64'(mq.size() == int'(DEPTH)));
      chk("m_valid", 64'(dec_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("m_pc", 64'(dec_pc), 64'(mq[0][63:32]));
        chk("m_instr", 64'(dec_instr), 64'(mq[0][31:0]));
      end else begin
        chk("m_pc_empty", 64'(dec_pc), 64'd0);
        chk("m_instr_empty", 64'(dec_instr), 64'h13);
      end
    end
  end

  function automatic logic [31:0] enc(input logic [31:0] pc);
    return {pc[15:0], 16'h0033} ^ 32'h5A00_0000;
  endfunction

  // One cycle of stimulus: drive after a falling edge, return at the next falling edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic s,
                     input logic f, input logic r);
    ifu_valid    = v;
    ifu_pc       = pc;
    ifu_instr    = enc(pc);
    stall_fetch  = s;
    flush_decode = f;
    rst          = r;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] next_pc;
    bit          pend;

    ifu_valid = 0; ifu_pc = 0; ifu_instr = 0;
    stall_fetch = 0; flush_decode = 0; rst = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);

    // Reset state
    cyc(0, 0, 0, 0, 0);
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_instr", 64'(dec_instr), 64'h13);
    chk("rst_count", 64'(fq_count), 64'd0);
    chk("rst_full", 64'(fq_full), 64'd0);

    // Streaming with no stall: one-cycle latency, occupancy stays at 1
    cyc(1, 32'h100, 0, 0, 0);
    chk("s_pc0", 64'(dec_pc), 64'h100);
    chk("s_instr0", 64'(dec_instr), 64'(enc(32'h100)));
    chk("s_cnt0", 64'(fq_count), 64'd1);
    cyc(1, 32'h104, 0, 0, 0);
    chk("s_pc1", 64'(dec_pc), 64'h104);
    chk("s_cnt1", 64'(fq_count), 64'd1);
    cyc(1, 32'h108, 0, 0, 0);
    chk("s_pc2", 64'(dec_pc), 64'h108);
    chk("s_cnt2", 64'(fq_count), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("s_drained", 64'(dec_valid), 64'd0);

    // Stall and overfill: the fifth is held by the IFU until space opens
    for (int i = 0; i < 4; i++) cyc(1, 32'h400 + 32'(4 * i), 1, 0, 0);
    chk("f_full", 64'(fq_full), 64'd1);
    chk("f_cnt", 64'(fq_count), 64'd4);
    cyc(1, 32'h410, 1, 0, 0);
    cyc(1, 32'h410, 1, 0, 0);
    chk("f_hold_cnt", 64'(fq_count), 64'd4);
    chk("f_hold_head", 64'(dec_pc), 64'h400);
    cyc(1, 32'h410, 0, 0, 0);
    chk("f_rel_cnt", 64'(fq_count), 64'd3);
    chk("f_rel_head", 64'(dec_pc), 64'h404);
    cyc(1, 32'h410, 0, 0, 0);
    chk("f_acc_cnt", 64'(fq_count), 64'd3);
    chk("f_acc_head", 64'(dec_pc), 64'h408);
    cyc(0, 0, 0, 0, 0);
    chk("f_d1", 64'(dec_pc), 64'h40c);
    cyc(0, 0, 0, 0, 0);
    chk("f_d2", 64'(dec_pc), 64'h410);
    chk("f_d2_instr", 64'(dec_instr), 64'(enc(32'h410)));
    cyc(0, 0, 0, 0, 0);
    chk("f_d3_empty", 64'(dec_valid), 64'd0);

    // Flush beats a same-cycle push and the stall
    for (int i = 0; i < 3; i++) cyc(1, 32'h600 + 32'(4 * i), 1, 0, 0);
    chk("x_cnt3", 64'(fq_count), 64'd3);
    cyc(1, 32'h200, 1, 1, 0);
    chk("x_cnt", 64'(fq_count), 64'd0);
    chk("x_valid", 64'(dec_valid), 64'd0);
    cyc(1, 32'h300, 0, 0, 0);
    chk("x_head", 64'(dec_pc), 64'h300);
    chk("x_head_cnt", 64'(fq_count), 64'd1);
    cyc(0, 0, 0, 0, 0);

    // Reset while full and stalled
    for (int i = 0; i < 4; i++) cyc(1, 32'h700 + 32'(4 * i), 1, 0, 0);
    chk("r_full", 64'(fq_full), 64'd1);
    cyc(1, 32'h7f0, 1, 0, 1);
    chk("r_cnt", 64'(fq_count), 64'd0);
    chk("r_fullclr", 64'(fq_full), 64'd0);
    chk("r_valid", 64'(dec_valid), 64'd0);
    chk("r_pc", 64'(dec_pc), 64'd0);
    chk("r_instr", 64'(dec_instr), 64'h13);
    cyc(1, 32'h500, 0, 0, 0);
    chk("r_push_head", 64'(dec_pc), 64'h500);

    // Random traffic with a well-behaved IFU: holds its request while refused
    next_pc = 32'h1000;
    pend    = 0;
    for (int n = 0; n < 600; n++) begin
      logic v, s, f, r;
      v = pend || ($urandom_range(0, 99) < 65);
      s = ($urandom_range(0, 99) < 40);
      f = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) < 1);
      pend = v;
      if (v && !fq_full && !f && !r) pend = 0;
      cyc(v, next_pc, s, f, r);
      if (v && !pend) next_pc = next_pc + 32'd4;
      if (f || r) begin
        pend    = 0;
        next_pc = next_pc + 32'h100;
      end
    end

    cyc(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
